// File: rtl/press_classifier.sv
// Button gesture classifier: turns the debounced level/tick into short, long and double-click pulses.
// Optional event counter output enabled by defining PRESS_CLASSIFIER_STATS_EN.
module press_classifier #(
    parameter int ClkRate   = 10_000_000,
    parameter int TickRate  = 1_000,
    parameter int LongTicks = 800,
    parameter int GapTicks  = 250
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        db_level_i,
    input  logic        db_tick_i,
    output logic        short_o,
    output logic        long_o,
    output logic        double_o,
    output logic        hold_o,
    output logic        busy_o
`ifdef PRESS_CLASSIFIER_STATS_EN
    ,
    output logic [15:0] event_cnt_o
`endif
);

    localparam int Div      = ClkRate / TickRate;
    localparam int MaxTicks = (LongTicks > GapTicks) ? LongTicks : GapTicks;
    localparam int PW       = $clog2(Div);
    localparam int TW       = $clog2(MaxTicks + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(Div - 1);
    localparam logic [TW-1:0] LONG_T     = TW'(LongTicks);
    localparam logic [TW-1:0] GAP_T      = TW'(GapTicks);
    localparam logic [TW-1:0] MAX_T      = TW'(MaxTicks);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        LONG_HOLD,
        WAIT_GAP,
        PRESS2
    } state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg;
    logic [TW-1:0] timer_reg;
    logic          ptick;
    logic          short_next, long_next, double_next;
    logic          short_reg, long_reg, double_reg, hold_reg, busy_reg;

    assign ptick = (presc_reg == PRESC_LAST);

    // Release is checked before the timer threshold, and press before the gap threshold.
    always_comb begin
        state_next  = state_reg;
        short_next  = 1'b0;
        long_next   = 1'b0;
        double_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (db_tick_i) state_next = PRESS1;
            end
            PRESS1: begin
                if (!db_level_i) begin
                    state_next = WAIT_GAP;
                end else if (timer_reg == LONG_T) begin
                    state_next = LONG_HOLD;
                    long_next  = 1'b1;
                end
            end
            LONG_HOLD: begin
                if (!db_level_i) state_next = IDLE;
            end
            WAIT_GAP: begin
                if (db_tick_i) begin
                    state_next = PRESS2;
                end else if (timer_reg == GAP_T) begin
                    state_next = IDLE;
                    short_next = 1'b1;
                end
            end
            PRESS2: begin
                if (!db_level_i) begin
                    state_next  = IDLE;
                    double_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            presc_reg  <= '0;
            timer_reg  <= '0;
            short_reg  <= 1'b0;
            long_reg   <= 1'b0;
            double_reg <= 1'b0;
            hold_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Every state change restarts the time base so thresholds are relative to entry.
            if (state_next != state_reg) begin
                presc_reg <= '0;
                timer_reg <= '0;
            end else begin
                presc_reg <= ptick ? '0 : presc_reg + PW'(1);
                if (ptick && (timer_reg != MAX_T)) timer_reg <= timer_reg + TW'(1);
            end
            short_reg  <= short_next;
            long_reg   <= long_next;
            double_reg <= double_next;
            hold_reg   <= (state_next == LONG_HOLD);
            busy_reg   <= (state_next != IDLE);
        end
    end

    assign short_o  = short_reg;
    assign long_o   = long_reg;
    assign double_o = double_reg;
    assign hold_o   = hold_reg;
    assign busy_o   = busy_reg;

`ifdef PRESS_CLASSIFIER_STATS_EN
    logic [15:0] event_cnt_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            event_cnt_reg <= '0;
        end else if (short_next || long_next || double_next) begin
            event_cnt_reg <= event_cnt_reg + 16'd1;
        end
    end

    assign event_cnt_o = event_cnt_reg;
`endif

endmodule
